// File: rtl/clock_div_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : clock_div_ctrl_if
// Description : Ratio-request channel for clock_div_ctrl. A requester offers
//               a new divide ratio with req_valid/req_div; the controller
//               answers with req_ready. A transfer occurs on a cycle where
//               req_valid and req_ready are both high.
//               Signals:
//                 req_valid  requester -> controller  ratio offered
//                 req_div    requester -> controller  requested ratio (0 = gate)
//                 req_ready  controller -> requester  ratio can be accepted
// Revision    : 1.0  initial release
// ============================================================================
interface clock_div_ctrl_if #(
    parameter int unsigned WIDTH = 8
);
    logic             req_valid;
    logic             req_ready;
    logic [WIDTH-1:0] req_div;

    // Requester side (config register block / testbench)
    modport master (
        output req_valid,
        output req_div,
        input  req_ready
    );

    // Controller side
    modport slave (
        input  req_valid,
        input  req_div,
        output req_ready
    );
endinterface
`default_nettype wire

// File: rtl/clock_div_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : clock_div_ctrl
// Description : Runtime-programmable clock divider. Produces a divided clock
//               level (div_clk, straight from a flop) and a one-cycle enable
//               (div_en) in the last fast cycle of each divided period.
//               New ratios arrive on a valid/ready channel and take effect
//               only at a period boundary, so no runt phase is ever emitted.
//               Ports:
//                 clock    fast clock, rising edge
//                 reset    synchronous active-high reset
//                 req      ratio request channel (slave side)
//                 done     one-cycle pulse, first cycle at a new ratio
//                 cur_div  ratio currently in effect (0 = gated)
//                 div_clk  divided clock level (registered)
//                 div_en   high in the last fast cycle of each period
// Revision    : 1.0  initial release
// ============================================================================
module clock_div_ctrl #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned INIT_DIV = 1
) (
    input  wire logic             clock,
    input  wire logic             reset,
    clock_div_ctrl_if.slave       req,
    output logic                  done,
    output logic [WIDTH-1:0]      cur_div,
    output logic                  div_clk,
    output logic                  div_en
);

    localparam logic [WIDTH-1:0] c_one      = WIDTH'(1);
    localparam logic [WIDTH-1:0] c_init_div = WIDTH'(INIT_DIV);
    // A ratio of 1 keeps both outputs permanently high, including at reset.
    localparam logic             c_init_one = (INIT_DIV == 32'd1);

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_PENDING = 1'b1
    } state_t;

    state_t           state_q,   state_d;
    logic [WIDTH-1:0] cur_div_q, cur_div_d;
    logic [WIDTH-1:0] pend_div_q, pend_div_d;
    logic [WIDTH-1:0] count_q,   count_d;
    logic             done_q,    done_d;
    logic             div_clk_q, div_clk_d;
    logic             div_en_q,  div_en_d;

    logic             w_running;
    logic             w_wrap;
    logic             w_xfer;
    logic             w_apply;

    // ------------------------------------------------------------------
    // Phase decode of the current cycle
    // ------------------------------------------------------------------
    assign w_running = (cur_div_q != '0);
    assign w_wrap    = w_running && (count_q == (cur_div_q - c_one));
    assign w_xfer    = req.req_valid && (state_q == ST_IDLE);
    // pend is only visible the cycle after the transfer, so a request taken
    // on a wrap cycle naturally waits for the following wrap.
    assign w_apply   = (state_q == ST_PENDING) && (!w_running || w_wrap);

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        cur_div_d  = cur_div_q;
        pend_div_d = pend_div_q;
        count_d    = count_q;
        done_d     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (w_xfer) begin
                    state_d    = ST_PENDING;
                    pend_div_d = req.req_div;
                end
            end
            ST_PENDING: begin
                if (w_apply) begin
                    state_d   = ST_IDLE;
                    cur_div_d = pend_div_q;
                    done_d    = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A new ratio always starts at phase 0, which keeps count below
        // the ratio without any extra clamping.
        if (w_apply || !w_running || w_wrap) begin
            count_d = '0;
        end else begin
            count_d = count_q + c_one;
        end

        // Outputs are decoded from the next phase and next ratio so that
        // they appear registered, aligned with count_q in the same cycle.
        div_clk_d = (cur_div_d != '0) && (count_d >= (cur_div_d >> 1));
        div_en_d  = (cur_div_d != '0) && (count_d == (cur_div_d - c_one));
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cur_div_q  <= c_init_div;
            pend_div_q <= '0;
            count_q    <= '0;
            done_q     <= 1'b0;
            div_clk_q  <= c_init_one;
            div_en_q   <= c_init_one;
        end else begin
            state_q    <= state_d;
            cur_div_q  <= cur_div_d;
            pend_div_q <= pend_div_d;
            count_q    <= count_d;
            done_q     <= done_d;
            div_clk_q  <= div_clk_d;
            div_en_q   <= div_en_d;
        end
    end

    assign req.req_ready = (state_q == ST_IDLE);
    assign done          = done_q;
    assign cur_div       = cur_div_q;
    assign div_clk       = div_clk_q;
    assign div_en        = div_en_q;

endmodule
`default_nettype wire

// File: doc/clock_div_ctrl.md
# clock_div_ctrl

Synthesizable, runtime-programmable clock-divider controller. It produces a divided clock level (`div_clk`) and a matching single-cycle enable (`div_en`) from the fast clock. Divide-ratio changes arrive through a valid/ready request port and are applied only at a period boundary, so the output never shows a truncated or runt phase. It sits between the chip-level clock/config register block and the divided-clock consumers. It replaces fixed-ratio simulation dividers wherever the ratio must change at runtime.

## Interface
Parameters:
- `WIDTH`, 8: width of the divide ratio.
- `INIT_DIV`, 1: ratio loaded at reset. Must be less than 2^WIDTH. A value of 0 means gated.

Ports:
- `clock`  in  1  fast input clock; all logic is on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `req_valid`  in  1  a new ratio is offered.
- `req_ready`  out  1  the controller can accept a ratio.
- `req_div`  in  WIDTH  requested ratio D; 0 means gate the output.
- `done`  out  1  one-cycle pulse in the first cycle of operation at the new ratio.
- `cur_div`  out  WIDTH  ratio currently in effect.
- `div_clk`  out  1  divided clock level; must be driven directly from a flop.
- `div_en`  out  1  high during the last fast cycle of each divided period.

## Operation
State registers:
- `cur_div`: the ratio in effect.
- `count`: a WIDTH-bit phase counter.
- `pend` / `pend_div`: a captured request that has not yet been applied.

Running (`cur_div` = D ≥ 1):
- `count` steps 0, 1, …, D−1, then wraps to 0.
- The wrap cycle is the cycle with `count` = D−1.
- `div_clk` = (`count` ≥ floor(D/2)). The output is low for floor(D/2) cycles, then high for ceil(D/2) cycles.
- The flop driving `div_clk` is loaded with the value for the next `count`. Any decode from `count` must be registered; a combinational decode is not allowed.
- `div_en` = (`count` = D−1).
- D = 1: `div_clk` is held 1 and `div_en` is held 1.

Gated (`cur_div` = 0):
- `count` is held at 0.
- `div_clk` and `div_en` are held at 0.

Request handshake:
- `req_ready` = !`pend`.
- A transfer happens on a cycle where `req_valid` && `req_ready`. On a transfer, `pend_div` ← `req_div` and `pend` ← 1.
- `req_div` is sampled only on transfer cycles.

Apply rules:
- When running, a pending request is applied at the end of a wrap cycle. The request must have been pending before that cycle; a request accepted during a wrap cycle waits for the next wrap.
- When gated, a pending request is applied at the end of the cycle after acceptance.
- On apply: `cur_div` ← `pend_div`, `count` ← 0, `pend` ← 0. `done` pulses in the following cycle, the first cycle at the new ratio.
- If the new ratio is 0, `done` still pulses and the output goes low.
- A request whose value equals `cur_div` is processed normally and produces `done`.

Control states:
- The block has two states: IDLE (`pend` = 0) and PENDING (`pend` = 1).
- IDLE → PENDING on a transfer.
- PENDING → IDLE on apply.
- No transfer is accepted while PENDING.

Arithmetic:
- `count` + 1 is computed in WIDTH bits. `count` never exceeds D−1, because a new ratio is loaded only together with `count` = 0.

## Timing
Reset values:
- `cur_div` = INIT_DIV, `count` = 0, `pend` = 0.
- `req_ready` = 1, `done` = 0, `div_en` = (INIT_DIV = 1).
- `div_clk` = 0, or 1 if INIT_DIV = 1.

Reset behaviour:
- The first cycle after reset is deasserted has `count` = 0.
- Reset asserted mid-period or while PENDING discards the pending ratio and resets `count`. No `done` is produced.

Latency:
- The transfer cycle is T.
- Running at ratio D: `done` falls in cycle T+1+k, where 1 ≤ k ≤ D. T+1+k is the first cycle after the next wrap that comes strictly after T.
- Gated: `done` falls in cycle T+2.
- `req_ready` returns high in the same cycle as `done`. A new transfer may happen in that cycle.

## Test plan
- Reset with INIT_DIV = 4, no requests → `div_clk` repeats 0,0,1,1. `div_en` is high when `count` = 3. `req_ready` = 1. `done` never pulses.
- At ratio 5, request D = 3 while `count` = 1 → held until the wrap at `count` = 4. `done` pulses with `count` = 0. The following pattern is 0,1,1 repeating. `cur_div` = 3.
- At ratio 4, request accepted exactly on a wrap cycle → not applied at that wrap. Applied at the next wrap, 4 cycles later. `req_ready` is low throughout.
- At ratio 3, request D = 0, then D = 7 → output goes low on the cycle `done` pulses. D = 7 is accepted on that same cycle, and `done` for D = 7 pulses 2 cycles after its acceptance. The pattern is then 0×3, 1×4.
- At ratio 1, request D = 2 → `done` pulses 2 cycles after acceptance. `div_clk` becomes 0,1,0,1. A second `req_valid` held high during PENDING is not accepted.
- While PENDING, assert `reset` for one cycle → `cur_div` = INIT_DIV and `pend` = 0. No `done` pulses afterwards.
